// File: rtl/calc_seq.sv
// Single-request arithmetic sequencer: one add/sub/mul/div in flight at a time.
// Mul and div iterate over four RUN cycles; add, sub and div-by-zero finish on the accept edge.
//
// state  | meaning
// S_IDLE | ready for a request, in_ready=1
// S_RUN  | iterating shift-add multiply or restoring divide, one bit per cycle
// S_DONE | result/err presented with out_valid=1 until out_ready
module calc_seq #(
  parameter logic [3:0] DIVZ_Q = 4'hF
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [1:0] op,
  input  logic [3:0] a,
  input  logic [3:0] b,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [7:0] result,
  output logic       err
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_MUL = 2'b10;
  localparam logic [1:0] OP_DIV = 2'b11;

  state_t     r_state;
  state_t     w_state_nxt;
  logic [1:0] r_op;
  logic [3:0] r_a;
  logic [3:0] r_b;
  logic [1:0] r_cnt;
  logic [7:0] r_acc;
  logic [4:0] r_rem;
  logic [3:0] r_quo;
  logic [7:0] r_result;
  logic       r_err;

  logic [4:0] w_add;
  logic [4:0] w_sub;
  logic [7:0] w_pp;
  logic [7:0] w_acc_nxt;
  logic [4:0] w_shift;
  logic       w_ge;
  logic [4:0] w_rem_nxt;
  logic [3:0] w_quo_nxt;
  logic       w_iterate;

  // Mul and nonzero-divisor div need the iterative RUN phase
  assign w_iterate = (op == OP_MUL) || ((op == OP_DIV) && (b != 4'd0));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      S_IDLE: begin
        if (in_valid) begin
          w_state_nxt = w_iterate ? S_RUN : S_DONE;
        end
      end
      S_RUN: begin
        if (r_cnt == 2'd3) begin
          w_state_nxt = S_DONE;
        end
      end
      S_DONE: begin
        if (out_ready) begin
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    w_add     = {1'b0, a} + {1'b0, b};
    w_sub     = {1'b0, a} - {1'b0, b};
    w_pp      = r_b[r_cnt] ? ({4'b0000, r_a} << r_cnt) : 8'h00;
    w_acc_nxt = r_acc + w_pp;
    // Dividend bits enter MSB first: cnt 0 takes a[3]
    w_shift   = {r_rem[3:0], r_a[2'd3 - r_cnt]};
    w_ge      = (w_shift >= {1'b0, r_b});
    w_rem_nxt = w_ge ? (w_shift - {1'b0, r_b}) : w_shift;
    w_quo_nxt = {r_quo[2:0], w_ge};
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_op     <= 2'b00;
      r_a      <= 4'h0;
      r_b      <= 4'h0;
      r_cnt    <= 2'd0;
      r_acc    <= 8'h00;
      r_rem    <= 5'h00;
      r_quo    <= 4'h0;
      r_result <= 8'h00;
      r_err    <= 1'b0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (in_valid) begin
            r_op  <= op;
            r_a   <= a;
            r_b   <= b;
            r_cnt <= 2'd0;
            r_acc <= 8'h00;
            r_rem <= 5'h00;
            r_quo <= 4'h0;
            unique case (op)
              OP_ADD: begin
                r_result <= {3'b000, w_add};
                r_err    <= 1'b0;
              end
              OP_SUB: begin
                r_result <= {3'b000, w_sub};
                r_err    <= 1'b0;
              end
              OP_DIV: begin
                if (b == 4'd0) begin
                  r_result <= {a, DIVZ_Q};
                  r_err    <= 1'b1;
                end
              end
              default: ;
            endcase
          end
        end
        S_RUN: begin
          r_cnt <= r_cnt + 2'd1;
          if (r_op == OP_MUL) begin
            r_acc <= w_acc_nxt;
          end else begin
            r_rem <= w_rem_nxt;
            r_quo <= w_quo_nxt;
          end
          if (r_cnt == 2'd3) begin
            r_result <= (r_op == OP_MUL) ? w_acc_nxt : {w_rem_nxt[3:0], w_quo_nxt};
            r_err    <= 1'b0;
          end
        end
        S_DONE: begin
          // Clearing on handshake keeps result/err zero outside DONE
          if (out_ready) begin
            r_result <= 8'h00;
            r_err    <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  assign in_ready  = (r_state == S_IDLE);
  assign out_valid = (r_state == S_DONE);
  assign result    = r_result;
  assign err       = r_err;

endmodule

// File: tb/tb_calc_seq.sv
// Directed vector bench for calc_seq: table of operations with hand-computed
// results and latencies, plus a mid-RUN reset sequence.
module tb_calc_seq;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid;
  logic       in_ready;
  logic [1:0] op;
  logic [3:0] a;
  logic [3:0] b;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] result;
  logic       err;

  int n_checks = 0;
  int n_errors = 0;

  calc_seq #(.DIVZ_Q(4'hF)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .op(op),
    .a(a),
    .b(b),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .result(result),
    .err(err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0] op;
    logic [3:0] a;
    logic [3:0] b;
    logic [7:0] res;
    logic       err;
    int         lat;
    int         hold;
  } vec_t;

  vec_t vecs[16];

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic do_op(input vec_t v);
    int lat;
    @(negedge clk);
    chk("idle_in_ready", int'(in_ready), 1);
    in_valid  = 1'b1;
    op        = v.op;
    a         = v.a;
    b         = v.b;
    out_ready = 1'b0;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    op       = 2'b00;
    a        = 4'h0;
    b        = 4'h0;
    lat      = 1;
    while (!out_valid && lat < 20) begin
      chk("run_in_ready", int'(in_ready), 0);
      chk("run_result_masked", int'(result), 0);
      chk("run_err_masked", int'(err), 0);
      in_valid = 1'b1;
      op       = 2'b00;
      a        = 4'h5;
      b        = 4'h5;
      @(negedge clk);
      lat++;
    end
    in_valid = 1'b0;
    chk("latency", lat, v.lat);
    chk("result", int'(result), int'(v.res));
    chk("err", int'(err), int'(v.err));
    chk("done_in_ready", int'(in_ready), 0);
    for (int i = 0; i < v.hold; i++) begin
      in_valid = 1'b1;
      op       = 2'b00;
      a        = 4'h1;
      b        = 4'h2;
      @(negedge clk);
      chk("hold_out_valid", int'(out_valid), 1);
      chk("hold_result", int'(result), int'(v.res));
      chk("hold_err", int'(err), int'(v.err));
      chk("hold_in_ready", int'(in_ready), 0);
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    in_valid  = 1'b0;
    chk("post_out_valid", int'(out_valid), 0);
    chk("post_in_ready", int'(in_ready), 1);
    chk("post_result", int'(result), 0);
    chk("post_err", int'(err), 0);
  endtask

  initial begin
    vecs[0]  = '{2'b00, 4'd9,  4'd8,  8'h11, 1'b0, 1, 0};
    vecs[1]  = '{2'b00, 4'd15, 4'd15, 8'h1E, 1'b0, 1, 0};
    vecs[2]  = '{2'b00, 4'd0,  4'd0,  8'h00, 1'b0, 1, 0};
    vecs[3]  = '{2'b01, 4'd3,  4'd5,  8'h1E, 1'b0, 1, 0};
    vecs[4]  = '{2'b01, 4'd9,  4'd4,  8'h05, 1'b0, 1, 0};
    vecs[5]  = '{2'b01, 4'd0,  4'd15, 8'h11, 1'b0, 1, 0};
    vecs[6]  = '{2'b10, 4'd15, 4'd15, 8'hE1, 1'b0, 5, 0};
    vecs[7]  = '{2'b10, 4'd0,  4'd9,  8'h00, 1'b0, 5, 0};
    vecs[8]  = '{2'b10, 4'd3,  4'd5,  8'h0F, 1'b0, 5, 2};
    vecs[9]  = '{2'b11, 4'd15, 4'd4,  8'h33, 1'b0, 5, 0};
    vecs[10] = '{2'b11, 4'd7,  4'd0,  8'h7F, 1'b1, 1, 2};
    vecs[11] = '{2'b11, 4'd13, 4'd3,  8'h14, 1'b0, 5, 3};
    vecs[12] = '{2'b11, 4'd3,  4'd7,  8'h30, 1'b0, 5, 0};
    vecs[13] = '{2'b11, 4'd15, 4'd1,  8'h0F, 1'b0, 5, 0};
    vecs[14] = '{2'b11, 4'd0,  4'd0,  8'h0F, 1'b1, 1, 0};
    vecs[15] = '{2'b10, 4'd6,  4'd7,  8'h2A, 1'b0, 5, 0};

    rst_n     = 1'b0;
    in_valid  = 1'b0;
    op        = 2'b00;
    a         = 4'h0;
    b         = 4'h0;
    out_ready = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_in_ready", int'(in_ready), 1);
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_result", int'(result), 0);
    chk("rst_err", int'(err), 0);
    rst_n = 1'b1;

    for (int i = 0; i < 16; i++) begin
      do_op(vecs[i]);
    end

    // Reset on the second RUN edge of a multiply aborts it silently
    @(negedge clk);
    in_valid = 1'b1;
    op       = 2'b10;
    a        = 4'd6;
    b        = 4'd7;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    chk("abort_running", int'(in_ready), 0);
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    chk("abort_in_ready", int'(in_ready), 1);
    chk("abort_out_valid", int'(out_valid), 0);
    chk("abort_result", int'(result), 0);
    chk("abort_err", int'(err), 0);
    do_op(vecs[15]);

    repeat (6) begin
      @(negedge clk);
      chk("quiet_out_valid", int'(out_valid), 0);
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/calc_seq.md
CALC_SEQ -- requirements
Module: calc_seq

Interface
REQ-001 Parameter DIVZ_Q, default 4'hF: quotient returned on divide-by-zero.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, synchronous, active-low.
REQ-004 in_valid  input  1  request present on op/a/b.
REQ-005 in_ready  output  1  block can accept a request.
REQ-006 op  input  2  00 add, 01 sub, 10 mul, 11 div.
REQ-007 a  input  4  operand A, unsigned; dividend for div.
REQ-008 b  input  4  operand B, unsigned; divisor for div.
REQ-009 out_valid  output  1  result valid.
REQ-010 out_ready  input  1  consumer takes result.
REQ-011 result  output  8  operation result, format per REQ-017..REQ-021.
REQ-012 err  output  1  divide-by-zero flag, qualified by out_valid.

Function
REQ-013 The block SHALL be a single-request controller: states IDLE, RUN, DONE; one operation in flight at a time.
REQ-014 The block SHALL assert in_ready only in IDLE; acceptance = in_valid & in_ready on a rising edge (edge E0), which latches op, a, b internally.
REQ-015 Transitions SHALL be: IDLE->DONE at E0 for add, sub, or div with b=0; IDLE->RUN at E0 for mul, or div with b!=0; RUN->DONE after exactly 4 iteration edges (E0+1..E0+4); DONE->IDLE on the edge where out_valid & out_ready.
REQ-016 The block SHALL ignore op/a/b/in_valid outside IDLE; no same-cycle accept on the DONE->IDLE edge.
REQ-017 add: result = {3'b000, a+b (5-bit, carry in bit 4)}.
REQ-018 sub: result[3:0] = (a-b) mod 16, result[4] = borrow (1 iff a<b), result[7:5] = 0.
REQ-019 mul: result = a*b as 8-bit unsigned product, computed by shift-add, one multiplier bit per RUN cycle, LSB first, 8-bit accumulator.
REQ-020 div (b!=0): restoring division, one quotient bit per RUN cycle, MSB first, 5-bit partial remainder (shift in next dividend bit, subtract b if partial >= b, quotient bit = 1 then); result = {remainder[3:0], quotient[3:0]}.
REQ-021 div (b=0): result = {a, DIVZ_Q}, err=1; err SHALL be 0 for every other completion.
REQ-022 out_valid SHALL be 1 exactly in DONE; latency accept->out_valid = 1 cycle for add/sub/div-by-zero, 5 cycles for mul/div.
REQ-023 While out_valid=1 and out_ready=0, result and err SHALL hold stable for any number of cycles.
REQ-024 result and err SHALL be 0 when not in DONE (mask internal iteration values).
REQ-025 An iteration counter (2 bits) SHALL count RUN cycles; counter wrap from 3 SHALL coincide with RUN->DONE.

Reset
REQ-026 On a rising edge with rst_n=0 the block SHALL enter IDLE: in_ready=1, out_valid=0, result=8'h00, err=0, counter=0, latched operands cleared.
REQ-027 Reset in RUN or DONE SHALL abort and discard the operation with no out_valid pulse; first accept possible on the first edge with rst_n=1.
REQ-028 Outputs SHALL be driven only from registers/state; no output depends combinationally on in_valid, out_ready, op, a, b.

Verification
REQ-029 add a=9 b=8, out_ready=1 -> out_valid at E0+1, result=8'h11, err=0, in_ready=1 next cycle.
REQ-030 sub a=3 b=5 -> result=8'h1E (low nibble E, borrow bit 4 = 1), err=0.
REQ-031 mul a=15 b=15 -> out_valid first high at E0+5 (in_ready=0 in between), result=8'hE1.
REQ-032 div a=15 b=4 -> result=8'h33 at E0+5; div a=7 b=0 -> result=8'h7F, err=1 at E0+1.
REQ-033 div a=13 b=3 with out_ready=0 for 3 cycles while in_valid=1 with other operands -> result=8'h14 held stable, in_ready=0, new request not taken until after handshake.
REQ-034 mul a=6 b=7 with rst_n=0 at second RUN edge -> next cycle in_ready=1, out_valid=0, result=8'h00; following mul a=6 b=7 completes with 8'h2A.
